// File: rtl/lkt_config_pkg.sv
// Shared lookup-table configuration and the result payload carried between
// the lookup stages, the serializer and the scoreboard.
package lkt_config_pkg;

    localparam int unsigned RESULT_WIDTH = 8;
    localparam int unsigned NUM_LOOKUPS  = 4;
    localparam int unsigned NUM_CHOICES  = 4;
    localparam int unsigned CHOICE_W     = $clog2(NUM_CHOICES);
    localparam int unsigned LANE_W       = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0] result;
        logic [CHOICE_W-1:0]     choice;
        logic                    hit;
    } lkt_result_t;

endpackage

// File: rtl/lkt_result_serializer_pkg.sv
// Serializer-local constants and helpers: counter width and saturation,
// lane index wrap for the round-robin scan.
package lkt_result_serializer_pkg;

    localparam int unsigned        CNT_W   = 16;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    // Wraps a lane index that can exceed the lane count by less than one lap.
    function automatic int unsigned lane_wrap(input int unsigned lane, input int unsigned n);
        return (lane >= n) ? lane - n : lane;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lkt_result_serializer_if.sv
// Lane inputs, serialized result stream and counter/status bundle of the
// result serializer. master = producer/consumer side, slave = serializer.
interface lkt_result_serializer_if
    import lkt_result_serializer_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH = lkt_config_pkg::RESULT_WIDTH,
    parameter int unsigned NUM_LOOKUPS  = lkt_config_pkg::NUM_LOOKUPS,
    parameter int unsigned NUM_CHOICES  = lkt_config_pkg::NUM_CHOICES
);
    localparam int unsigned CHOICE_W = $clog2(NUM_CHOICES);
    localparam int unsigned LANE_W   = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1;

    logic [NUM_LOOKUPS-1:0]                   in_valid;
    logic [NUM_LOOKUPS-1:0]                   in_ready;
    logic [NUM_LOOKUPS-1:0][RESULT_WIDTH-1:0] in_result;
    logic [NUM_LOOKUPS-1:0][CHOICE_W-1:0]     in_choice;
    logic [NUM_LOOKUPS-1:0]                   in_hit;

    logic                    out_valid;
    logic                    out_ready;
    logic [RESULT_WIDTH-1:0] out_result;
    logic [CHOICE_W-1:0]     out_choice;
    logic                    out_hit;
    logic [LANE_W-1:0]       out_lane;

    logic                    cnt_clr;
    logic [CNT_W-1:0]        hit_cnt;
    logic [CNT_W-1:0]        miss_cnt;
    logic [NUM_LOOKUPS-1:0]  lane_full;

    modport master (
        output in_valid, in_result, in_choice, in_hit, out_ready, cnt_clr,
        input  in_ready, out_valid, out_result, out_choice, out_hit, out_lane,
               hit_cnt, miss_cnt, lane_full
    );

    modport slave (
        input  in_valid, in_result, in_choice, in_hit, out_ready, cnt_clr,
        output in_ready, out_valid, out_result, out_choice, out_hit, out_lane,
               hit_cnt, miss_cnt, lane_full
    );

endinterface

// File: rtl/lkt_lane_fifo.sv
// Per-lane synchronous FIFO; pointers carry one extra wrap bit so full and
// empty fall out of the pointer compare without an occupancy counter.
module lkt_lane_fifo #(
    parameter type         entry_t = lkt_config_pkg::lkt_result_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t head_c,
    output logic   full_c,
    output logic   empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    // Push is refused on a full lane even when the same cycle pops.
    assign do_push = push_i & ~full_c;
    assign do_pop  = pop_i & ~empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lkt_result_serializer.sv
// Buffers NUM_LOOKUPS parallel lookup results in per-lane FIFOs and drains
// them round-robin into one registered result stream with hit/miss counters.
module lkt_result_serializer
    import lkt_result_serializer_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH = lkt_config_pkg::RESULT_WIDTH,
    parameter int unsigned NUM_LOOKUPS  = lkt_config_pkg::NUM_LOOKUPS,
    parameter int unsigned NUM_CHOICES  = lkt_config_pkg::NUM_CHOICES,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lkt_result_serializer_if.slave   bus
);
    localparam int unsigned CHOICE_W = $clog2(NUM_CHOICES);
    localparam int unsigned LANE_W   = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0] result;
        logic [CHOICE_W-1:0]     choice;
        logic                    hit;
    } beat_t;

    beat_t                  wr_beat [NUM_LOOKUPS];
    beat_t                  head_c  [NUM_LOOKUPS];
    logic [NUM_LOOKUPS-1:0] full_c, empty_c, push_c, pop_c;

    logic [LANE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]      grant_c, scan_lane_c;
    logic                   grant_valid_c, load_c, fire_c;

    beat_t                  out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANE_W-1:0]      out_lane_q, out_lane_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    for (genvar g = 0; g < NUM_LOOKUPS; g++) begin : g_lane
        assign push_c[g]  = bus.in_valid[g] & ~full_c[g];
        assign wr_beat[g] = '{result: bus.in_result[g],
                              choice: bus.in_choice[g],
                              hit:    bus.in_hit[g]};

        lkt_lane_fifo #(
            .entry_t (beat_t),
            .DEPTH   (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push_c[g]),
            .wdata_i (wr_beat[g]),
            .pop_i   (pop_c[g]),
            .head_c  (head_c[g]),
            .full_c  (full_c[g]),
            .empty_c (empty_c[g])
        );
    end

    assign bus.in_ready  = ~full_c;
    assign bus.lane_full = full_c;

    // First non-empty lane at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_c       = '0;
        scan_lane_c   = '0;
        for (int unsigned off = 0; off < NUM_LOOKUPS; off++) begin
            scan_lane_c = LANE_W'(lane_wrap(32'(rr_ptr_q) + off, NUM_LOOKUPS));
            if (!grant_valid_c && !empty_c[scan_lane_c]) begin
                grant_valid_c = 1'b1;
                grant_c       = scan_lane_c;
            end
        end
    end

    assign load_c = (~out_valid_q | bus.out_ready) & grant_valid_c;
    assign pop_c  = load_c ? (NUM_LOOKUPS'(1) << grant_c) : '0;
    assign fire_c = out_valid_q & bus.out_ready;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        if (load_c) begin
            rr_ptr_d    = (32'(grant_c) == NUM_LOOKUPS - 1) ? '0 : grant_c + LANE_W'(1);
            out_d       = head_c[grant_c];
            out_valid_d = 1'b1;
            out_lane_d  = grant_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle handshake.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.cnt_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (fire_c) begin
            if (out_q.hit) hit_cnt_d  = sat_inc(hit_cnt_q);
            else           miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_q.result;
    assign bus.out_choice = out_q.choice;
    assign bus.out_hit    = out_q.hit;
    assign bus.out_lane   = out_lane_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_lkt_result_serializer.sv
// Directed bench for lkt_result_serializer: reset, latency, round-robin,
// backpressure, output hold, counter saturation/clear and async reset.
module tb_lkt_result_serializer;

    localparam int unsigned RW = 8;
    localparam int unsigned NL = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned FD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    lkt_result_serializer_if #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC)) bus ();

    lkt_result_serializer #(
        .RESULT_WIDTH (RW),
        .NUM_LOOKUPS  (NL),
        .NUM_CHOICES  (NC),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid  = '0;
        bus.in_result = '0;
        bus.in_choice = '0;
        bus.in_hit    = '0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 8'h00 || bus.out_choice !== 2'd0 || bus.out_hit !== 1'b0 || bus.out_lane !== 2'd0) begin
            bad++; $display("FAIL reset_out_fields got=%h/%0d/%0b/%0d want=0/0/0/0", bus.out_result, bus.out_choice, bus.out_hit, bus.out_lane); end
        total++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.hit_cnt, bus.miss_cnt); end
        total++; if (bus.in_ready !== 4'hF || bus.lane_full !== 4'h0) begin bad++; $display("FAIL reset_ready_full got=%b/%b want=1111/0000", bus.in_ready, bus.lane_full); end
        total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL reset_rr_ptr got=%0d want=0", dut.rr_ptr_q); end
    endtask

    task automatic test_single_beat();
        apply_reset();
        bus.out_ready    = 1'b1;
        bus.in_valid     = 4'b0001;
        bus.in_result[0] = 8'hA5;
        bus.in_choice[0] = 2'd1;
        bus.in_hit[0]    = 1'b1;
        tick();
        bus.in_valid = '0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_not_yet got=%0b want=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd0 || bus.out_result !== 8'hA5 || bus.out_choice !== 2'd1 || bus.out_hit !== 1'b1) begin
            bad++; $display("FAIL single_beat got=v%0b l%0d r%h c%0d h%0b want=v1 l0 rA5 c1 h1", bus.out_valid, bus.out_lane, bus.out_result, bus.out_choice, bus.out_hit); end
        total++; if (bus.hit_cnt !== 16'd0) begin bad++; $display("FAIL single_cnt_early got=%0d want=0", bus.hit_cnt); end
        tick();
        total++; if (bus.hit_cnt !== 16'd1 || bus.miss_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL single_after got=hit%0d miss%0d v%0b want=hit1 miss0 v0", bus.hit_cnt, bus.miss_cnt, bus.out_valid); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.in_result[i] = 8'(8'h10 + i);
            bus.in_choice[i] = 2'(i);
            bus.in_hit[i]    = (i % 2 == 0);
        end
        tick();
        bus.in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'(i) || bus.out_result !== 8'(8'h10 + i) || bus.out_choice !== 2'(i)) begin
                bad++; $display("FAIL rr_beat%0d got=v%0b l%0d r%h c%0d want=v1 l%0d r%h c%0d", i, bus.out_valid, bus.out_lane, bus.out_result, bus.out_choice, i, 8'(8'h10 + i), i); end
        end
        tick();
        total++; if (bus.hit_cnt !== 16'd2 || bus.miss_cnt !== 16'd2 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL rr_counts got=hit%0d miss%0d v%0b want=hit2 miss2 v0", bus.hit_cnt, bus.miss_cnt, bus.out_valid); end
        total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL rr_ptr_wrap got=%0d want=0", dut.rr_ptr_q); end
    endtask

    task automatic test_backpressure();
        int idx;
        logic acc;
        apply_reset();
        bus.out_ready = 1'b0;
        // Output register takes the first beat, the FIFO the next four.
        for (int k = 0; k < 5; k++) begin
            bus.in_valid[2]  = 1'b1;
            bus.in_result[2] = 8'(8'h30 + k);
            bus.in_choice[2] = 2'(k);
            bus.in_hit[2]    = 1'b1;
            total++; if (bus.in_ready[2] !== 1'b1) begin bad++; $display("FAIL bp_ready_beat%0d got=%0b want=1", k, bus.in_ready[2]); end
            tick();
        end
        bus.in_result[2] = 8'h35;
        bus.in_choice[2] = 2'd1;
        total++; if (bus.lane_full[2] !== 1'b1 || bus.in_ready[2] !== 1'b0) begin
            bad++; $display("FAIL bp_full got=full%0b rdy%0b want=full1 rdy0", bus.lane_full[2], bus.in_ready[2]); end
        repeat (2) tick();
        total++; if (bus.lane_full !== 4'b0100 || bus.out_result !== 8'h30 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold got=full%b r%h v%0b want=full0100 r30 v1", bus.lane_full, bus.out_result, bus.out_valid); end
        bus.out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.out_valid === 1'b1) begin
                total++; if (bus.out_result !== 8'(8'h30 + idx) || bus.out_lane !== 2'd2) begin
                    bad++; $display("FAIL bp_order%0d got=r%h l%0d want=r%h l2", idx, bus.out_result, bus.out_lane, 8'(8'h30 + idx)); end
                idx++;
            end
            acc = bus.in_valid[2] & bus.in_ready[2];
            tick();
            if (acc) bus.in_valid[2] = 1'b0;
        end
        total++; if (idx != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", idx); end
        total++; if (bus.hit_cnt !== 16'd6) begin bad++; $display("FAIL bp_hits got=%0d want=6", bus.hit_cnt); end
    endtask

    task automatic test_output_stability();
        apply_reset();
        bus.out_ready    = 1'b0;
        bus.in_valid     = 4'b1010;
        bus.in_result[1] = 8'hC3; bus.in_choice[1] = 2'd2; bus.in_hit[1] = 1'b0;
        bus.in_result[3] = 8'h7E; bus.in_choice[3] = 2'd3; bus.in_hit[3] = 1'b1;
        tick();
        bus.in_valid = '0;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'hC3 || bus.out_choice !== 2'd2 || bus.out_hit !== 1'b0 || bus.out_lane !== 2'd1 || bus.miss_cnt !== 16'd0 || bus.hit_cnt !== 16'd0) begin
                bad++; $display("FAIL stable_c%0d got=v%0b r%h c%0d h%0b l%0d m%0d want=v1 rC3 c2 h0 l1 m0", c, bus.out_valid, bus.out_result, bus.out_choice, bus.out_hit, bus.out_lane, bus.miss_cnt); end
        end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_lane !== 2'd3 || bus.out_result !== 8'h7E || bus.miss_cnt !== 16'd1) begin
            bad++; $display("FAIL stable_release got=l%0d r%h m%0d want=l3 r7E m1", bus.out_lane, bus.out_result, bus.miss_cnt); end
    endtask

    task automatic test_counter_saturation();
        int  hs_cnt;
        int  cyc;
        logic hs;
        apply_reset();
        bus.out_ready    = 1'b1;
        bus.in_valid     = 4'b0001;
        bus.in_result[0] = 8'h5A;
        bus.in_hit[0]    = 1'b1;
        hs_cnt = 0;
        cyc    = 0;
        while (hs_cnt < 65537 && cyc < 70000) begin
            hs = bus.out_valid & bus.out_ready;
            tick();
            cyc++;
            if (hs) begin
                hs_cnt++;
                if (hs_cnt == 65534) begin
                    total++; if (bus.hit_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", bus.hit_cnt); end
                end
            end
        end
        bus.in_valid = '0;
        total++; if (cyc != 65539) begin bad++; $display("FAIL sat_throughput got=%0d cycles want=65539", cyc); end
        total++; if (bus.hit_cnt !== 16'hFFFF || bus.miss_cnt !== 16'd0) begin
            bad++; $display("FAIL sat_value got=%h/%0d want=ffff/0", bus.hit_cnt, bus.miss_cnt); end
        repeat (4) tick();
        bus.in_valid  = 4'b0010;
        bus.in_hit[1] = 1'b0;
        tick();
        bus.in_valid = '0;
        tick();
        bus.cnt_clr = 1'b1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_hit !== 1'b0) begin bad++; $display("FAIL clr_setup got=v%0b h%0b want=v1 h0", bus.out_valid, bus.out_hit); end
        tick();
        bus.cnt_clr = 1'b0;
        total++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin bad++; $display("FAIL clr_value got=%h/%h want=0/0", bus.hit_cnt, bus.miss_cnt); end
        bus.in_valid = 4'b0010;
        tick();
        bus.in_valid = '0;
        repeat (2) tick();
        total++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd1) begin bad++; $display("FAIL clr_resume got=%0d/%0d want=0/1", bus.hit_cnt, bus.miss_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1011;
        bus.in_hit    = 4'b1011;
        tick();
        bus.in_valid = '0;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'hF) begin bad++; $display("FAIL arst_setup got=v%0b rdy%b want=v1 rdy1111", bus.out_valid, bus.in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'hF || bus.lane_full !== 4'h0) begin
            bad++; $display("FAIL arst_immediate got=v%0b rdy%b full%b want=v0 rdy1111 full0000", bus.out_valid, bus.in_ready, bus.lane_full); end
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0 || bus.hit_cnt !== 16'd0) begin
                bad++; $display("FAIL arst_after%0d got=v%0b hit%0d want=v0 hit0", c, bus.out_valid, bus.hit_cnt); end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_output_stability();
        test_counter_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
